// File: rtl/imem_loader.sv
// Byte-stream program loader: parses A5/LEN/payload/CSUM frames, writes 32-bit words into
// instruction memory and holds the processor in reset until a frame with a good checksum lands.
module imem_loader #(
    parameter int unsigned ADDRESS_WIDTH  = 12,
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter bit          BOOT_HOLD      = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [31:0]              imem_data,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLimit   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]   DepthMax = 17'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum
    } state_e;

    state_e        state_q;
    logic [7:0]    len_hi_q;
    logic [15:0]   len_q;
    logic [15:0]   word_idx_q;
    logic [1:0]    byte_idx_q;
    logic [23:0]   asm_q;
    logic [7:0]    csum_q;
    logic [TW-1:0] tcnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            len_hi_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            tcnt_q     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_data  <= '0;
            cpu_hold   <= BOOT_HOLD;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            if (state_q == StIdle) begin
                if (rx_valid && rx_byte == 8'hA5) begin
                    state_q    <= StLenHi;
                    busy       <= 1'b1;
                    cpu_hold   <= 1'b1;
                    error      <= 1'b0;
                    csum_q     <= '0;
                    word_idx_q <= '0;
                    byte_idx_q <= '0;
                    tcnt_q     <= '0;
                end
            end else if (!rx_valid) begin
                // Inter-byte silence inside a frame; abort once the budget is spent.
                if (tcnt_q == TLimit) begin
                    state_q  <= StIdle;
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b1;
                    tcnt_q   <= '0;
                end else begin
                    tcnt_q <= tcnt_q + TW'(1);
                end
            end else begin
                tcnt_q <= '0;
                case (state_q)
                    StLenHi: begin
                        len_hi_q <= rx_byte;
                        state_q  <= StLenLo;
                    end
                    StLenLo: begin
                        len_q <= {len_hi_q, rx_byte};
                        if ({1'b0, len_hi_q, rx_byte} > DepthMax) begin
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else if ({len_hi_q, rx_byte} == 16'd0) begin
                            state_q <= StCsum;
                        end else begin
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        csum_q     <= csum_q ^ rx_byte;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        // Little-endian: earlier bytes drift down toward bits 7:0.
                        asm_q      <= {rx_byte, asm_q[23:8]};
                        if (byte_idx_q == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_data  <= {rx_byte, asm_q};
                            imem_addr  <= ADDRESS_WIDTH'(word_idx_q);
                            word_idx_q <= word_idx_q + 16'd1;
                            if (word_idx_q == len_q - 16'd1) begin
                                state_q <= StCsum;
                            end
                        end
                    end
                    StCsum: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        if (rx_byte == csum_q) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
